// File: rtl/ctrl_frame_issuer_n.sv
// ctrl_frame_issuer_n: CPU-loaded control-frame transmitter.
// Firmware fills a word-wide frame RAM over iomem, then writes cfg reg0 to start. The block
// requests FIFO ownership through the mutex handshake, then streams the frame to every masked
// PHY-TX FIFO. It can zero-pad to MIN_LEN, append a CRC-32 FCS, stall on almost-full and abort.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   iomem_*            picosoc bus (one-cycle ready, registered rdata)
//   o_fifo_din/del     shared byte and end-of-frame marker
//   fifo_wren/afull    per-port write enable / almost-full
//   mutex_req/val      per-port ownership request / grant
//   irq                mirrors the sticky done bit
module ctrl_frame_issuer_n #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [7:0]  CFG_BASE  = 8'h15,
  parameter logic [7:0]  RAM_BASE  = 8'h05,
  parameter int unsigned MIN_LEN   = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iomem_valid,
  output logic               iomem_ready,
  input  logic [3:0]         iomem_wstrb,
  input  logic [31:0]        iomem_addr,
  input  logic [31:0]        iomem_wdata,
  output logic [31:0]        iomem_rdata,
  output logic [7:0]         o_fifo_din,
  output logic               o_fifo_del,
  input  logic [N_PORTS-1:0] fifo_afull,
  output logic [N_PORTS-1:0] fifo_wren,
  output logic [N_PORTS-1:0] mutex_req,
  input  logic [N_PORTS-1:0] mutex_val,
  output logic               irq
);
  localparam int unsigned AW     = $clog2(RAM_WORDS);
  localparam logic [16:0] MaxLen = 17'(RAM_WORDS * 4);
  localparam logic [16:0] MinLen = 17'(MIN_LEN);

  typedef enum logic [2:0] {StIdle, StWait, StData, StPad, StFcs, StEnd} state_e;

  state_e             state_q;
  logic [31:0]        ram [RAM_WORDS];
  logic               ready_q, del_q, done_q, err_q, fcs_q, tx_fcs_q, abort_q, aborted_q;
  logic [31:0]        rdata_q, crc_q;
  logic [7:0]         din_q;
  logic [N_PORTS-1:0] wren_q, req_q, mask_q, tx_mask_q;
  logic [15:0]        len_q, tx_len_q, sent_cnt_q, abort_cnt_q;
  logic [16:0]        idx_q;

  logic               cfg_sel, ram_sel, wr_cfg0, start_wr, abort_wr, abort_hit, start_ok;
  logic               stalled, grant_ok, emit_ok, idle;
  logic [15:0]        len_new;
  logic [N_PORTS-1:0] mask_new;
  logic               fcs_new;
  logic [7:0]         mask_rd, cur_byte;
  logic [16:0]        pad_len, total, idx_inc;
  logic [31:0]        tx_word, fcs_val;
  logic [1:0]         fcs_sel;
  state_e             nxt_st;
  logic               unused_bits;

  assign unused_bits = ^{iomem_addr, iomem_wdata};

  assign cfg_sel  = iomem_valid && !ready_q && (iomem_addr[31:24] == CFG_BASE);
  assign ram_sel  = iomem_valid && !ready_q && (iomem_addr[31:24] == RAM_BASE);
  assign wr_cfg0  = cfg_sel && (iomem_wstrb != 4'b0) && !iomem_addr[2];
  assign start_wr = wr_cfg0 && iomem_wstrb[3] && iomem_wdata[31];
  assign abort_wr = wr_cfg0 && iomem_wstrb[3] && iomem_wdata[28];
  assign abort_hit = abort_wr || abort_q;
  assign idle     = (state_q == StIdle);

  // The starting write validates against the field values it is writing itself.
  assign len_new  = {iomem_wstrb[1] ? iomem_wdata[15:8] : len_q[15:8],
                     iomem_wstrb[0] ? iomem_wdata[7:0]  : len_q[7:0]};
  assign mask_new = iomem_wstrb[2] ? iomem_wdata[16 +: N_PORTS] : mask_q;
  assign fcs_new  = iomem_wstrb[3] ? iomem_wdata[27] : fcs_q;
  assign start_ok = idle && (len_new != 16'd0) && ({1'b0, len_new} <= MaxLen) &&
                    (mask_new != '0);

  assign stalled  = |(fifo_afull & tx_mask_q);
  assign grant_ok = (mutex_val == req_q) && !stalled;

  always_comb begin
    mask_rd = '0;
    mask_rd[N_PORTS-1:0] = mask_q;
    pad_len = {1'b0, tx_len_q};
    if (tx_fcs_q && (pad_len < MinLen)) pad_len = MinLen;
    total   = tx_fcs_q ? pad_len + 17'd4 : pad_len;
    idx_inc = idx_q + 17'd1;
    fcs_val = ~crc_q;
    fcs_sel = idx_q[1:0] - pad_len[1:0];
    tx_word = ram[idx_q[AW+1:2]];
    // Byte position alone picks data, pad or FCS; the WAIT exit emits byte 0 directly.
    cur_byte = 8'h00;
    if (idx_q < {1'b0, tx_len_q}) begin
      cur_byte = tx_word[{idx_q[1:0], 3'b000} +: 8];
    end else if (idx_q >= pad_len) begin
      unique case (fcs_sel)
        2'd0: cur_byte = fcs_val[31:24];
        2'd1: cur_byte = fcs_val[23:16];
        2'd2: cur_byte = fcs_val[15:8];
        2'd3: cur_byte = fcs_val[7:0];
      endcase
    end
    if (idx_inc == total)                 nxt_st = StEnd;
    else if (idx_inc < {1'b0, tx_len_q})  nxt_st = StData;
    else if (idx_inc < pad_len)           nxt_st = StPad;
    else                                  nxt_st = StFcs;
    emit_ok = 1'b0;
    unique case (state_q)
      StWait:               emit_ok = !abort_hit && grant_ok;
      StData, StPad, StFcs: emit_ok = !abort_hit && !stalled;
      default:              emit_ok = 1'b0;
    endcase
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame RAM: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_sel && (iomem_wstrb != 4'b0)) begin
      for (int b = 0; b < 4; b++) begin
        if (iomem_wstrb[b]) ram[iomem_addr[AW+1:2]][8*b +: 8] <= iomem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;   ready_q <= 1'b0;   rdata_q <= '0;   din_q <= '0;
      del_q <= 1'b0;       wren_q <= '0;      req_q <= '0;     mask_q <= '0;
      tx_mask_q <= '0;     len_q <= '0;       tx_len_q <= '0;  fcs_q <= 1'b0;
      tx_fcs_q <= 1'b0;    done_q <= 1'b0;    err_q <= 1'b0;   abort_q <= 1'b0;
      aborted_q <= 1'b0;   idx_q <= '0;       crc_q <= '1;
      sent_cnt_q <= '0;    abort_cnt_q <= '0;
    end else begin
      ready_q <= 1'b0;
      wren_q  <= '0;
      del_q   <= 1'b0;
      if (cfg_sel || ram_sel) begin
        ready_q <= 1'b1;
        if (ram_sel)              rdata_q <= ram[iomem_addr[AW+1:2]];
        else if (iomem_addr[2])   rdata_q <= {abort_cnt_q, sent_cnt_q};
        else rdata_q <= {1'b0, idle, !idle, 1'b0, fcs_q, done_q, err_q, 1'b0, mask_rd, len_q};
      end
      if (wr_cfg0) begin
        len_q  <= len_new;
        mask_q <= mask_new;
        fcs_q  <= fcs_new;
        if (iomem_wstrb[3] && iomem_wdata[26]) done_q <= 1'b0;
        if (iomem_wstrb[3] && iomem_wdata[25]) err_q  <= 1'b0;
        // Abort outranks a simultaneous start, which is then dropped without error.
        if (start_wr && !abort_wr && !start_ok) err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_wr && !abort_wr && start_ok) begin
            tx_len_q  <= len_new;
            tx_mask_q <= mask_new;
            tx_fcs_q  <= fcs_new;
            req_q     <= mask_new;
            idx_q     <= '0;
            crc_q     <= '1;
            aborted_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (abort_hit) begin
            req_q     <= '0;
            aborted_q <= 1'b1;
            state_q   <= StEnd;
          end
        end
        StData, StPad, StFcs: begin
          if (abort_hit) begin
            if (stalled) begin
              abort_q <= 1'b1;
            end else begin
              din_q     <= 8'h00;
              wren_q    <= tx_mask_q;
              del_q     <= 1'b1;
              err_q     <= 1'b1;
              req_q     <= '0;
              abort_q   <= 1'b0;
              aborted_q <= 1'b1;
              state_q   <= StEnd;
            end
          end
        end
        StEnd: begin
          done_q  <= 1'b1;
          crc_q   <= '1;
          abort_q <= 1'b0;
          if (aborted_q) abort_cnt_q <= abort_cnt_q + 16'd1;
          else           sent_cnt_q  <= sent_cnt_q + 16'd1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (emit_ok) begin
        din_q   <= cur_byte;
        wren_q  <= tx_mask_q;
        del_q   <= (idx_inc == total);
        idx_q   <= idx_inc;
        state_q <= nxt_st;
        if (idx_q < pad_len) crc_q <= crc_step(crc_q, cur_byte);
        if (nxt_st == StEnd) req_q <= '0;
      end
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign o_fifo_din  = din_q;
  assign o_fifo_del  = del_q;
  assign fifo_wren   = wren_q;
  assign mutex_req   = req_q;
  assign irq         = done_q;

endmodule

// File: tb/tb_ctrl_frame_issuer_n.sv
// Directed bench for ctrl_frame_issuer_n: FCS/pad frame, multi-port plain frame, back-pressure,
// delayed grant, abort plus invalid start, and reset in the middle of padding.
module tb_ctrl_frame_issuer_n;
  localparam int unsigned NP = 4;
  localparam logic [31:0] Reg0 = 32'h1500_0000;
  localparam logic [31:0] Reg1 = 32'h1500_0004;
  localparam logic [31:0] RamA = 32'h0500_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          iomem_valid, iomem_ready;
  logic [3:0]    iomem_wstrb;
  logic [31:0]   iomem_addr, iomem_wdata, iomem_rdata;
  logic [7:0]    o_fifo_din;
  logic          o_fifo_del;
  logic [NP-1:0] fifo_afull, fifo_wren, mutex_req, mutex_val;
  logic          irq;
  logic          grant_en;

  int n_checks = 0;
  int n_errors = 0;
  int stray_del = 0;

  logic [7:0]    q_din[$];
  logic          q_del[$];
  logic [NP-1:0] q_wren[$];

  ctrl_frame_issuer_n #(.N_PORTS(NP)) dut (
    .clk(clk), .rst(rst),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .o_fifo_din(o_fifo_din), .o_fifo_del(o_fifo_del), .fifo_afull(fifo_afull),
    .fifo_wren(fifo_wren), .mutex_req(mutex_req), .mutex_val(mutex_val), .irq(irq)
  );

  always #5 clk = ~clk;
  assign mutex_val = grant_en ? mutex_req : '0;

  always @(negedge clk) begin
    if (fifo_wren != '0) begin
      q_din.push_back(o_fifo_din);
      q_del.push_back(o_fifo_del);
      q_wren.push_back(fifo_wren);
    end else if (o_fifo_del) begin
      stray_del++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd);
    int n;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!iomem_ready && n < 8);
    check_eq("bus_ack", {31'b0, iomem_ready}, 32'd1);
    rd = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bus(a, d, s, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus(a, 32'h0, 4'b0, rd);
    check_eq(tag, rd, exp);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!irq && n < 1000) begin @(negedge clk); n++; end
    check_eq({tag, "_irq"}, {31'b0, irq}, 32'd1);
  endtask

  task automatic wait_count(input string tag, input int cnt);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (q_din.size() < cnt && n < 1000);
    check_eq({tag, "_reach"}, q_din.size(), cnt);
  endtask

  task automatic clear_q();
    q_din.delete(); q_del.delete(); q_wren.delete();
  endtask

  // Bit-serial reflected CRC-32, reported as the final (inverted) register value.
  function automatic logic [31:0] crc32(input logic [7:0] d[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] exp[$], input logic [NP-1:0] m);
    int dels = 0;
    int bad_wren = 0;
    check_eq({tag, "_count"}, q_din.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_din.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), {24'h0, q_din[i]}, {24'h0, exp[i]});
    foreach (q_del[i]) if (q_del[i]) dels++;
    foreach (q_wren[i]) if (q_wren[i] != m) bad_wren++;
    check_eq({tag, "_del_count"}, dels, 1);
    if (q_del.size() > 0) check_eq({tag, "_del_last"}, {31'b0, q_del[q_del.size()-1]}, 32'd1);
    check_eq({tag, "_wren_mask"}, bad_wren, 0);
  endtask

  initial begin
    logic [7:0]  exp[$];
    logic [31:0] c;
    int          n0;
    rst = 1'b1; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
    fifo_afull = '0; grant_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check_eq("rst_wren", {28'b0, fifo_wren}, 32'd0);
    check_eq("rst_req", {28'b0, mutex_req}, 32'd0);
    check_eq("rst_irq", {31'b0, irq}, 32'd0);
    rd_chk("rst_reg0", Reg0, 32'h4000_0000);
    rd_chk("rst_reg1", Reg1, 32'h0000_0000);

    // RAM byte k = k.
    for (int w = 0; w < 32; w++) begin
      wr(RamA + 32'(4 * w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF);
    end
    rd_chk("ram_rd3", RamA + 32'd12, 32'h0F0E_0D0C);

    // 1: len 16, FCS, port 0 -> 16 data, 44 pad, 4 FCS.
    clear_q();
    wr(Reg0, 32'h8801_0010, 4'hF);
    wait_irq("t1");
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'(i));
    for (int i = 0; i < 44; i++) exp.push_back(8'h00);
    c = crc32(exp);
    exp.push_back(c[31:24]); exp.push_back(c[23:16]); exp.push_back(c[15:8]); exp.push_back(c[7:0]);
    check_frame("t1", exp, 4'b0001);
    rd_chk("t1_reg0", Reg0, 32'h4C01_0010);
    rd_chk("t1_reg1", Reg1, 32'h0000_0001);
    wr(Reg0, 32'h0400_0000, 4'b1000);
    check_eq("t1_irq_clr", {31'b0, irq}, 32'd0);

    // 2: len 100, no FCS, ports 1 and 3.
    clear_q();
    wr(Reg0, 32'h800A_0064, 4'hF);
    wait_irq("t2");
    exp.delete();
    for (int i = 0; i < 100; i++) exp.push_back(8'(i));
    check_frame("t2", exp, 4'b1010);
    rd_chk("t2_reg1", Reg1, 32'h0000_0002);
    wr(Reg0, 32'h0400_0000, 4'b1000);

    // 3: afull on port 1 for 5 cycles mid-data.
    clear_q();
    wr(Reg0, 32'h8002_0028, 4'hF);
    wait_count("t3", 10);
    fifo_afull[1] = 1'b1;
    n0 = q_din.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_eq($sformatf("t3_stall%0d", i), q_din.size(), n0);
    end
    fifo_afull[1] = 1'b0;
    wait_irq("t3");
    exp.delete();
    for (int i = 0; i < 40; i++) exp.push_back(8'(i));
    check_frame("t3", exp, 4'b0010);
    wr(Reg0, 32'h0400_0000, 4'b1000);

    // 4: grant withheld for 20 cycles.
    clear_q();
    grant_en = 1'b0;
    wr(Reg0, 32'h8001_0008, 4'hF);
    repeat (20) @(negedge clk);
    rd_chk("t4_busy", Reg0, 32'h2001_0008);
    check_eq("t4_no_wren", q_din.size(), 0);
    check_eq("t4_req", {28'b0, mutex_req}, 32'd1);
    @(negedge clk);
    check_eq("t4_wren_pre", {28'b0, fifo_wren}, 32'd0);
    grant_en = 1'b1;
    @(negedge clk);
    check_eq("t4_first_wren", {28'b0, fifo_wren}, 32'd1);
    wait_irq("t4");
    exp.delete();
    for (int i = 0; i < 8; i++) exp.push_back(8'(i));
    check_frame("t4", exp, 4'b0001);
    wr(Reg0, 32'h0400_0000, 4'b1000);

    // 5: abort lands on byte 10, then a len=0 start is refused.
    clear_q();
    wr(Reg0, 32'h8001_0028, 4'hF);
    wait_count("t5", 9);
    wr(Reg0, 32'h1000_0000, 4'b1000);
    wait_irq("t5");
    exp.delete();
    for (int i = 0; i < 10; i++) exp.push_back(8'(i));
    exp.push_back(8'h00);
    check_frame("t5", exp, 4'b0001);
    check_eq("t5_req", {28'b0, mutex_req}, 32'd0);
    rd_chk("t5_reg0", Reg0, 32'h4601_0028);
    rd_chk("t5_reg1", Reg1, 32'h0001_0004);
    wr(Reg0, 32'h8001_0000, 4'hF);
    repeat (5) @(negedge clk);
    rd_chk("t5_len0_reg0", Reg0, 32'h4601_0000);
    check_eq("t5_len0_nobytes", q_din.size(), 11);
    check_eq("t5_len0_req", {28'b0, mutex_req}, 32'd0);
    wr(Reg0, 32'h0600_0000, 4'b1000);

    // 6: reset while padding.
    clear_q();
    wr(Reg0, 32'h8801_0004, 4'hF);
    wait_count("t6", 20);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_wren", {28'b0, fifo_wren}, 32'd0);
    check_eq("t6_req", {28'b0, mutex_req}, 32'd0);
    check_eq("t6_del", {31'b0, o_fifo_del}, 32'd0);
    rst = 1'b0;
    rd_chk("t6_reg0", Reg0, 32'h4000_0000);
    rd_chk("t6_reg1", Reg1, 32'h0000_0000);
    n0 = 0;
    foreach (q_del[i]) if (q_del[i]) n0++;
    check_eq("t6_no_del", n0, 0);
    check_eq("stray_del", stray_del, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
